// File: rtl/l2_line_adaptor_pkg.sv
// Shared geometry and types for the L2 <-> memory line/burst adaptor.
package l2_types;
  localparam int S_OFFSET = 5;
  localparam int S_BURST  = 64;
  localparam int S_ADDR   = 32;

  localparam int LINE_W  = 8 * (2 ** S_OFFSET);
  localparam int BURST_W = S_BURST;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BURST,
    READ_BURST,
    DONE
  } l2_adaptor_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] burst_t;
  typedef logic [S_ADDR-1:0]  addr_t;
endpackage

// File: rtl/l2_line_adaptor_if.sv
// Bundle of L2-side and memory-side signals of the line adaptor.
// slave = adaptor view, master = the L2/memory environment driving it.
interface l2_line_adaptor_if;
  import l2_types::*;

  logic   read_i;
  logic   write_i;
  addr_t  address_i;
  line_t  line_i;
  line_t  line_o;
  logic   resp_o;
  burst_t burst_i;
  burst_t burst_o;
  addr_t  address_o;
  logic   read_o;
  logic   write_o;
  logic   resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/l2_line_adaptor.sv
// Burst adaptor: streams an L2 line to memory as beats (writeback) or
// gathers memory beats into a line (fill). One transaction at a time.
module l2_line_adaptor
  import l2_types::*;
(
  input  logic              clk,
  input  logic              rst,
  l2_line_adaptor_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  l2_adaptor_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  line_t             line_q, line_d;
  addr_t             addr_q, addr_d;

  // Byte offset inside the line is dropped when aligning the address.
  logic unused_offset_bits;
  assign unused_offset_bits = ^bus.address_i[S_OFFSET-1:0];

  // State, beat counter, line buffer and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: request capture, beat stepping, fill slice writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read is dropped, not queued.
        if (bus.write_i) begin
          line_d  = bus.line_i;
          addr_d  = {bus.address_i[S_ADDR-1:S_OFFSET], {S_OFFSET{1'b0}}};
          cnt_d   = '0;
          state_d = WRITE_BURST;
        end else if (bus.read_i) begin
          addr_d  = {bus.address_i[S_ADDR-1:S_OFFSET], {S_OFFSET{1'b0}}};
          cnt_d   = '0;
          state_d = READ_BURST;
        end
      end
      WRITE_BURST: begin
        if (bus.resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      READ_BURST: begin
        if (bus.resp_i) begin
          line_d[cnt_q*BURST_W +: BURST_W] = bus.burst_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    bus.read_o    = (state_q == READ_BURST);
    bus.write_o   = (state_q == WRITE_BURST);
    bus.resp_o    = (state_q == DONE);
    bus.address_o = addr_q;
    bus.line_o    = line_q;
    bus.burst_o   = '0;
    if (state_q == WRITE_BURST) begin
      bus.burst_o = line_q[cnt_q*BURST_W +: BURST_W];
    end
  end

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Directed, table-driven bench for l2_line_adaptor.
module tb_l2_line_adaptor;
  import l2_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  l2_line_adaptor_if bus ();

  l2_line_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              wr;
    logic              rd;
    logic [31:0]       addr;
    logic [31:0]       exp_addr;
    logic [3:0][63:0]  beats;    // beats[0] is the first beat / lowest bits
    logic [31:0]       pattern;  // resp_i per burst cycle, bit 0 first
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int p;
    line_t exp_line;
    exp_line = v.beats;
    @(negedge clk);
    bus.address_i = v.addr;
    bus.line_i    = exp_line;
    bus.write_i   = v.wr;
    bus.read_i    = v.rd;
    bus.resp_i    = 1'b0;
    @(negedge clk);
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    bus.line_i  = ~exp_line;  // must not disturb a captured writeback
    k = 0;
    p = 0;
    while (k < BEATS && p < 32) begin
      chk({v.name, " read_o"},    256'(bus.read_o),    256'(v.rd & ~v.wr));
      chk({v.name, " write_o"},   256'(bus.write_o),   256'(v.wr));
      chk({v.name, " address_o"}, 256'(bus.address_o), 256'(v.exp_addr));
      chk({v.name, " resp_o"},    256'(bus.resp_o),    256'(0));
      if (v.wr) chk({v.name, " burst_o"}, 256'(bus.burst_o), 256'(v.beats[k]));
      bus.resp_i  = v.pattern[p];
      bus.burst_i = v.pattern[p] ? v.beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk);
      if (bus.resp_i) k++;
      p++;
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    if (k < BEATS) begin
      checks++;
      errors++;
      $display("FAIL %s timeout beats=%0d required=%0d", v.name, k, BEATS);
    end
    chk({v.name, " done resp_o"},  256'(bus.resp_o),  256'(1));
    chk({v.name, " done read_o"},  256'(bus.read_o),  256'(0));
    chk({v.name, " done write_o"}, 256'(bus.write_o), 256'(0));
    chk({v.name, " line_o"},       bus.line_o,        exp_line);
    @(negedge clk);
    chk({v.name, " idle resp_o"},  256'(bus.resp_o),  256'(0));
    chk({v.name, " held line_o"},  bus.line_o,        exp_line);
    chk({v.name, " held addr"},    256'(bus.address_o), 256'(v.exp_addr));
    $display("txn %s done after %0d cycles", v.name, p);
  endtask

  initial begin
    logic [11:0] exp_rd;
    logic [11:0] exp_rs;
    checks = 0;
    errors = 0;
    bus.read_i = 0; bus.write_i = 0; bus.address_i = '0; bus.line_i = '0;
    bus.burst_i = '0; bus.resp_i = 0;

    vecs[0] = '{"fill_basic", 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1220,
                {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 32'hFFFF_FFFF};
    vecs[1] = '{"writeback", 1'b1, 1'b0, 32'h8000_0040, 32'h8000_0040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 32'hFFFF_FFFF};
    vecs[2] = '{"fill_gaps", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                {64'h3333_0000_0000_0004, 64'h2222_0000_0000_0003,
                 64'h1111_0000_0000_0002, 64'h0123_4567_89AB_CDEF}, 32'h0000_0059};
    vecs[3] = '{"rd_wr_both", 1'b1, 1'b1, 32'h0000_007F, 32'h0000_0060,
                {64'h4444_4444_0000_0004, 64'h3333_3333_0000_0003,
                 64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001}, 32'h0000_00DB};

    // Reset state
    rst = 1'b1;
    #2;
    chk("rst read_o",    256'(bus.read_o),    256'(0));
    chk("rst write_o",   256'(bus.write_o),   256'(0));
    chk("rst resp_o",    256'(bus.resp_o),    256'(0));
    chk("rst address_o", 256'(bus.address_o), 256'(0));
    chk("rst burst_o",   256'(bus.burst_o),   256'(0));
    chk("rst line_o",    bus.line_o,          256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // resp_i in IDLE must not start anything
    bus.resp_i = 1'b1;
    @(negedge clk);
    bus.resp_i = 1'b0;
    chk("idle resp_i read_o",  256'(bus.read_o),  256'(0));
    chk("idle resp_i write_o", 256'(bus.write_o), 256'(0));

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset in the middle of a fill after two beats
    @(negedge clk);
    bus.address_i = 32'h0000_5555;
    bus.read_i    = 1'b1;
    @(negedge clk);
    bus.read_i  = 1'b0;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hFEED_0000_0000_0000;
    @(negedge clk);
    bus.burst_i = 64'hFEED_0000_0000_0001;
    @(negedge clk);
    bus.resp_i = 1'b0;
    chk("pre-rst read_o", 256'(bus.read_o), 256'(1));
    rst = 1'b1;
    #1;
    chk("midrst read_o",    256'(bus.read_o),    256'(0));
    chk("midrst resp_o",    256'(bus.resp_o),    256'(0));
    chk("midrst address_o", 256'(bus.address_o), 256'(0));
    chk("midrst line_o",    bus.line_o,          256'(0));
    chk("midrst burst_o",   256'(bus.burst_o),   256'(0));
    @(negedge clk);
    chk("midrst held resp_o", 256'(bus.resp_o), 256'(0));
    rst = 1'b0;
    $display("txn reset_mid_fill done");
    run_vec(vecs[0]);

    // read_i held high: fills back to back with one IDLE cycle between
    exp_rd = 12'b001111_001111;  // bit 0 first cycle
    exp_rs = 12'b010000_010000;
    @(negedge clk);
    bus.address_i = 32'h0000_0100;
    bus.read_i    = 1'b1;
    bus.resp_i    = 1'b1;
    bus.burst_i   = 64'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b read_o c%0d", c), 256'(bus.read_o), 256'(exp_rd[c]));
      chk($sformatf("b2b resp_o c%0d", c), 256'(bus.resp_o), 256'(exp_rs[c]));
    end
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    $display("txn back_to_back done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_line_adaptor.md
Name: l2_line_adaptor

Overview:
Burst adaptor between the L2 cache datapath and main memory.
- Writeback: takes a full L2 line (read out of the L2 data array) and streams it to memory as 64-bit beats.
- Fill: collects 64-bit memory beats into one full line for the L2 data array's write port.
- One transaction in flight at a time.

Parameters:
s_offset, 5, log2 bytes per line (line = 8*2**s_offset bits = 256)
s_burst, 64, memory beat width in bits
s_addr, 32, address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
read_i  input  1  L2 requests line fill, sampled in IDLE
write_i  input  1  L2 requests line writeback, sampled in IDLE
address_i  input  s_addr  line address from L2
line_i  input  8*2**s_offset  writeback line from the L2 data array
line_o  output  8*2**s_offset  assembled fill line
resp_o  output  1  one-cycle completion pulse to L2
burst_i  input  s_burst  memory read beat data
burst_o  output  s_burst  memory write beat data
address_o  output  s_addr  line-aligned memory address
read_o  output  1  memory read request
write_o  output  1  memory write request
resp_i  input  1  memory beat accept/valid

Behaviour:
- Reset:
  - One clock is used. Reset is asynchronous and active-high.
  - On reset, state=IDLE, beat counter=0, and every output is 0 (line_o, resp_o, burst_o, address_o, read_o, write_o).
  - Reset asserted mid-burst aborts the burst immediately. No resp_o is issued.
- Beats per line: BEATS = 8*2**s_offset/s_burst (4 at default).
- Beat counter width is log2(BEATS). It counts up from 0 and reaches BEATS-1; it never wraps within a transaction.
- States: IDLE, WRITE_BURST, READ_BURST, DONE.
- IDLE:
  - On write_i=1:
    - Capture line_i into an internal line register.
    - Set address_o={address_i[s_addr-1:s_offset], s_offset'b0}.
    - Go to WRITE_BURST.
  - Else on read_i=1: capture the aligned address and go to READ_BURST.
  - If read_i and write_i are both 1, write wins. read_i is ignored, and L2 must re-request the fill after resp_o.
  - resp_i is ignored in IDLE.
- WRITE_BURST:
  - write_o=1, address_o held, burst_o = captured line bits [s_burst*k +: s_burst] for beat k. Beat 0 is the lowest bits.
  - Each cycle with resp_i=1 advances k.
  - resp_i=0 holds the beat; gaps are allowed.
  - On resp_i=1 at k=BEATS-1, go to DONE. write_o drops in the DONE cycle.
- READ_BURST:
  - read_o=1, address_o held.
  - Each cycle with resp_i=1 writes burst_i into line register slice k and advances k.
  - On resp_i=1 at k=BEATS-1, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then return to IDLE.
  - read_o and write_o are 0.
  - read_i and write_i are not sampled in DONE. The earliest new request is sampled the cycle after DONE.
- line_o is driven from the line register.
  - For a fill, line_o is valid during DONE and held until the next transaction modifies the register.
  - line_i changes after capture have no effect on the writeback.
- Minimum latency, request sampled at cycle T with resp_i tied high:
  - First beat at T+1, last beat at T+BEATS.
  - resp_o at T+BEATS+1, so 5 cycles at default.
- address_o holds its last value in IDLE.
- Counter resets to 0 on entering DONE.

Decomposition:
- Package l2_types holds:
  - constants LINE_W=8*2**s_offset, BURST_W=64, BEATS=LINE_W/BURST_W, CNT_W=$clog2(BEATS);
  - typedef enum l2_adaptor_state_t {IDLE, WRITE_BURST, READ_BURST, DONE};
  - typedefs line_t and burst_t.
- No sub-module. The counter and state machine stay in one module.

Test Plan:
1. Reset mid-READ_BURST after 2 beats:
   - Required: all outputs 0 immediately (async), state IDLE.
   - A subsequent read completes all 4 beats from beat 0.
2. Fill, address_i=32'h0000_1234, resp_i high continuously, beats 64'hA0..A3:
   - address_o=32'h0000_1220, read_o high for 4 cycles.
   - resp_o pulses at T+5.
   - line_o={A3,A2,A1,A0}.
3. Writeback, line_i=256'h{DDDD..,CCCC..,BBBB..,AAAA..}:
   - burst_o sequence AAAA.., BBBB.., CCCC.., DDDD.. on resp_i beats, write_o high.
   - line_i is changed after capture; burst_o must still emit the captured data.
4. Fill with resp_i pattern 1,0,0,1,1,0,1:
   - Exactly 4 beats captured in order.
   - resp_o one cycle after the 4th resp_i.
   - read_o held through the gaps.
5. read_i=1 and write_i=1 in the same IDLE cycle:
   - WRITE_BURST entered, read_o stays 0 throughout.
   - resp_o exactly once.
6. read_i held high continuously:
   - Back-to-back fills, one cycle of IDLE between DONE and the next read_o.
   - resp_i pulses in IDLE are ignored.
